// File: rtl/sysbus_pkg.sv
// System bus encodings and writeback-queue drain states shared by the writeback path.
package sysbus_pkg;

    localparam logic [3:0]  SYSBUS_WRITE  = 4'd1;
    localparam logic [3:0]  SYSBUS_MEMORY = 4'd1;
    localparam logic [15:0] WBQ_WRITE_TAG = (16'(SYSBUS_WRITE) << 12) | (16'(SYSBUS_MEMORY) << 8);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        END
    } wbq_state_t;

endpackage

// File: rtl/wbq_storage.sv
// Circular line store with head/tail/count and per-entry line compare; enqueue lands next edge.
// enq_ready drops at DEPTH (a pop does not free the slot that cycle); WBQ_COALESCE_EN merges matching unlocked lines.
module wbq_storage #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_W     = 512,
    parameter int OFS        = 6,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [ADDR_WIDTH-1:0]     enq_addr,
    input  logic [LINE_W-1:0]         enq_data,
    input  logic                      pop,
    input  logic                      lock_head,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr,
    output logic                      lookup_hit,
    output logic [ADDR_WIDTH-OFS-1:0] head_line,
    output logic [LINE_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int TW = ADDR_WIDTH - OFS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TW-1:0]     line_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [TW-1:0]     enq_line;
    logic [TW-1:0]     look_line;
    logic              merge_hit;
    logic              enq_fire;
    logic              alloc;

    assign enq_line  = enq_addr[ADDR_WIDTH-1:OFS];
    assign look_line = lookup_addr[ADDR_WIDTH-1:OFS];

`ifdef WBQ_COALESCE_EN
    logic [PW-1:0] merge_idx;
    logic          unused_ofs;
    assign unused_ofs = ^{enq_addr[OFS-1:0], lookup_addr[OFS-1:0]};

    // The head being written to the bus must not change under the drain.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (line_q[i] == enq_line) && !(lock_head && (head == PW'(i)))) begin
                merge_hit = 1'b1;
                merge_idx = PW'(i);
            end
        end
    end
`else
    logic unused_ofs;
    assign unused_ofs = ^{enq_addr[OFS-1:0], lookup_addr[OFS-1:0], lock_head};
    assign merge_hit  = 1'b0;
`endif

    assign enq_ready = (count != CW'(DEPTH)) || merge_hit;
    assign enq_fire  = enq_valid && enq_ready;
    assign alloc     = enq_fire && !merge_hit;
    assign empty     = (count == '0);
    assign head_line = line_q[head];
    assign head_data = data_q[head];

    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (line_q[i] == look_line)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld_q <= '0;
        end else begin
            if (pop) begin
                head        <= head + 1'b1;
                vld_q[head] <= 1'b0;
            end
            if (alloc) begin
                tail        <= tail + 1'b1;
                vld_q[tail] <= 1'b1;
            end
            if (alloc && !pop) begin
                count <= count + 1'b1;
            end else if (!alloc && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            line_q[tail] <= enq_line;
            data_q[tail] <= enq_data;
        end
`ifdef WBQ_COALESCE_EN
        if (enq_fire && merge_hit) begin
            data_q[merge_idx] <= enq_data;
        end
`endif
    end

endmodule

// File: rtl/writeback_queue.sv
// Dirty-line writeback engine: queue, arbitrate, then address beat + BEATS data beats; address 3 cycles after enqueue at best.
// Enqueue stalls only when full; address beat holds for reqack, data beats are unacked. Option: WBQ_COALESCE_EN.
module writeback_queue
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int ADDR_WIDTH     = 64,
    parameter int LINE_BYTES     = 64,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [ADDR_WIDTH-1:0]     enq_addr,
    input  logic [LINE_BYTES*8-1:0]   enq_data,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr,
    output logic                      lookup_hit,
    output logic                      abtr_reqcyc,
    input  logic                      abtr_grant,
    output logic                      bus_busy,
    output logic                      main_bus_reqcyc,
    input  logic                      main_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      wb_done
);

    localparam int BEATS  = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int OFS    = $clog2(LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    wbq_state_t                state;
    wbq_state_t                next_state;
    logic [BW-1:0]             beat;
    logic [ADDR_WIDTH-OFS-1:0] head_line;
    logic [LINE_W-1:0]         head_data;
    logic [ADDR_WIDTH-1:0]     line_base;
    logic                      pop;
    logic                      lock_head;

    assign pop       = (state == END);
    assign lock_head = (state == ADDR) || (state == DATA) || (state == END);
    assign line_base = {head_line, {OFS{1'b0}}};

    wbq_storage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_W     (LINE_W),
        .OFS        (OFS),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk         (clk),
        .reset       (reset),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_addr    (enq_addr),
        .enq_data    (enq_data),
        .pop         (pop),
        .lock_head   (lock_head),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .head_line   (head_line),
        .head_data   (head_data),
        .count       (count),
        .empty       (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty)                      next_state = ARB;
            ARB:     if (abtr_grant)                  next_state = ADDR;
            ADDR:    if (main_bus_reqack)             next_state = DATA;
            DATA:    if (beat == BW'(BEATS - 1))      next_state = END;
            END:                                      next_state = IDLE;
            default:                                  next_state = IDLE;
        endcase
    end

    // Beat index restarts on every address beat so a re-acked line always begins at beat 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat <= '0;
        end else if (state == ADDR) begin
            beat <= '0;
        end else if (state == DATA) begin
            beat <= beat + 1'b1;
        end
    end

    always_comb begin
        abtr_reqcyc     = 1'b0;
        bus_busy        = 1'b0;
        main_bus_reqcyc = 1'b0;
        main_bus_req    = '0;
        main_bus_reqtag = '0;
        wb_done         = 1'b0;
        case (state)
            ARB: begin
                abtr_reqcyc = 1'b1;
            end
            ADDR: begin
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = BUS_DATA_WIDTH'(line_base);
                main_bus_reqtag = BUS_TAG_WIDTH'(WBQ_WRITE_TAG);
            end
            DATA: begin
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = BUS_DATA_WIDTH'(head_data >> (int'(beat) * BUS_DATA_WIDTH));
                main_bus_reqtag = BUS_TAG_WIDTH'(WBQ_WRITE_TAG);
            end
            END: begin
                bus_busy = 1'b1;
                wb_done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Random and directed stimulus against a queue-of-lines bus-protocol model for writeback_queue.
module tb_writeback_queue;

    localparam int BEATS = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [57:0]  line;
        logic [511:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         enq_valid;
    logic         enq_ready;
    logic [63:0]  enq_addr;
    logic [511:0] enq_data;
    logic [63:0]  lookup_addr;
    logic         lookup_hit;
    logic         abtr_reqcyc;
    logic         abtr_grant;
    logic         bus_busy;
    logic         main_bus_reqcyc;
    logic         main_bus_reqack;
    logic [63:0]  main_bus_req;
    logic [12:0]  main_bus_reqtag;
    logic [2:0]   count;
    logic         empty;
    logic         wb_done;

    writeback_queue dut (
        .clk             (clk),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_addr        (enq_addr),
        .enq_data        (enq_data),
        .lookup_addr     (lookup_addr),
        .lookup_hit      (lookup_hit),
        .abtr_reqcyc     (abtr_reqcyc),
        .abtr_grant      (abtr_grant),
        .bus_busy        (bus_busy),
        .main_bus_reqcyc (main_bus_reqcyc),
        .main_bus_reqack (main_bus_reqack),
        .main_bus_req    (main_bus_req),
        .main_bus_reqtag (main_bus_reqtag),
        .count           (count),
        .empty           (empty),
        .wb_done         (wb_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: lines waiting in order; tphase 0 = off bus, 1 = address, 2..BEATS+1 = data, BEATS+2 = end.
    ent_t mq[$];
    int   tphase             = 0;
    bit   prev_idle_nonempty = 1'b0;
    int   addr_len           = 0;

    logic [63:0] addr_log[$];
    logic [63:0] tag_log[$];
    int          addr_cyc_log[$];
    int          len_log[$];
    logic [63:0] beat_log[$];
    int          done_cyc_log[$];
    int          last_beat_cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [63:0] e_req;
        logic [63:0] e_tag;
        bit          e_arb, e_busy, e_rc, e_done, e_hit, e_rdy, fire;
        int          mi, sz;
        cyc++;
        if (!reset) begin
            mq.delete();
            tphase             = 0;
            prev_idle_nonempty = 1'b0;
            addr_len           = 0;
        end else begin
            sz = mq.size();
            if (tphase != 0 && sz == 0) begin
                check("model_head_missing", 64'd0, 64'd1);
                tphase = 0;
            end
            e_arb  = (tphase == 0) && prev_idle_nonempty;
            e_busy = (tphase != 0);
            e_rc   = (tphase >= 1) && (tphase <= BEATS + 1);
            e_done = (tphase == BEATS + 2);
            e_req  = 64'd0;
            e_tag  = 64'd0;
            if (tphase == 1) begin
                e_req = {mq[0].line, 6'b0};
                e_tag = 64'h1100;
            end else if (e_rc) begin
                e_req = mq[0].data[(tphase - 2) * 64 +: 64];
                e_tag = 64'h1100;
            end
            e_hit = 1'b0;
            mi    = -1;
            for (int i = 0; i < sz; i++) begin
                if (mq[i].line == lookup_addr[63:6]) e_hit = 1'b1;
                if (mq[i].line == enq_addr[63:6] && !(tphase != 0 && i == 0)) mi = i;
            end
`ifdef WBQ_COALESCE_EN
            e_rdy = (sz != DEPTH) || (mi >= 0);
`else
            e_rdy = (sz != DEPTH);
            mi    = -1;
`endif
            check("count", 64'(count), 64'(sz));
            check("empty", 64'(empty), 64'(sz == 0));
            check("enq_ready", 64'(enq_ready), 64'(e_rdy));
            check("lookup_hit", 64'(lookup_hit), 64'(e_hit));
            check("abtr_reqcyc", 64'(abtr_reqcyc), 64'(e_arb));
            check("bus_busy", 64'(bus_busy), 64'(e_busy));
            check("reqcyc", 64'(main_bus_reqcyc), 64'(e_rc));
            check("req", main_bus_req, e_req);
            check("reqtag", 64'(main_bus_reqtag), e_tag);
            check("wb_done", 64'(wb_done), 64'(e_done));

            if (tphase == 1) begin
                if (addr_len == 0) begin
                    addr_log.push_back(main_bus_req);
                    tag_log.push_back(64'(main_bus_reqtag));
                    addr_cyc_log.push_back(cyc);
                end
                if (main_bus_reqcyc && main_bus_req == addr_log[addr_log.size() - 1]) addr_len++;
            end
            if (e_rc && tphase >= 2) begin
                beat_log.push_back(main_bus_req);
                last_beat_cyc = cyc;
            end
            if (wb_done) done_cyc_log.push_back(cyc);

            // Effects of the coming clock edge.
            fire = enq_valid && e_rdy;
            if (fire) begin
                if (mi >= 0) mq[mi].data = enq_data;
                else begin
                    ent_t e;
                    e.line = enq_addr[63:6];
                    e.data = enq_data;
                    mq.push_back(e);
                end
            end
            prev_idle_nonempty = (tphase == 0) && (sz > 0);
            if (tphase == 0) begin
                if (e_arb && abtr_grant) tphase = 1;
            end else if (tphase == 1) begin
                if (main_bus_reqack) begin
                    len_log.push_back(addr_len);
                    addr_len = 0;
                    tphase   = 2;
                end
            end else if (tphase <= BEATS + 1) begin
                tphase++;
            end else begin
                void'(mq.pop_front());
                tphase = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mkline(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < BEATS; k++) l[k * 64 +: 64] = base + 64'(k);
        return l;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k * 32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic enq(input logic [63:0] a, input logic [511:0] d, output int acc);
        int n = 0;
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        #1;
        while (!enq_ready && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (!enq_ready) check("enq_timeout", 64'd0, 64'd1);
        tick();
        acc       = cyc;
        enq_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cyc_log.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cyc_log.size() < target) check("done_timeout", 64'(done_cyc_log.size()), 64'(target));
    endtask

    initial begin
        int acc, ai, bi, nd, n;
        reset           = 1'b0;
        enq_valid       = 1'b0;
        enq_addr        = '0;
        enq_data        = '0;
        lookup_addr     = '0;
        abtr_grant      = 1'b0;
        main_bus_reqack = 1'b0;
        repeat (3) tick();

        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_bus_busy", 64'(bus_busy), 64'd0);
        check("rst_abtr_reqcyc", 64'(abtr_reqcyc), 64'd0);
        check("rst_req", main_bus_req, 64'd0);
        reset = 1'b1;
        tick();

        // Single line at minimum latency.
        abtr_grant      = 1'b1;
        main_bus_reqack = 1'b1;
        ai = addr_log.size();
        bi = beat_log.size();
        nd = done_cyc_log.size();
        enq(64'h1234, mkline(64'h10), acc);
        wait_done(nd + 1, 100);
        if (addr_log.size() > ai) begin
            check("single_addr", addr_log[ai], 64'h1200);
            check("single_tag", tag_log[ai], 64'h1100);
            check("single_latency", 64'(addr_cyc_log[ai] - acc), 64'd3);
        end else check("single_addr_seen", 64'd0, 64'd1);
        check("single_beats", 64'(beat_log.size() - bi), 64'd8);
        for (int k = 0; k < BEATS && bi + k < beat_log.size(); k++) check("single_beat", beat_log[bi + k], 64'h10 + 64'(k));
        if (done_cyc_log.size() > nd) check("single_done_gap", 64'(done_cyc_log[nd] - last_beat_cyc), 64'd1);

        // Fill with the grant low, then drain in order.
        abtr_grant = 1'b0;
        for (int k = 0; k < DEPTH; k++) enq(64'h3000 + 64'(k * 64), mkline(64'h100 * (k + 1)), acc);
        enq_addr = 64'h3100;
        #1;
        check("fill_count", 64'(count), 64'd4);
        check("fill_enq_ready", 64'(enq_ready), 64'd0);
        enq_valid = 1'b1;
        repeat (3) tick();
        enq_valid = 1'b0;
        check("fill_fifth_rejected", 64'(count), 64'd4);
        ai = addr_log.size();
        nd = done_cyc_log.size();
        abtr_grant = 1'b1;
        wait_done(nd + 1, 100);
        check("fill_ready_after_pop", 64'(enq_ready), 64'd1);
        wait_done(nd + 4, 200);
        for (int k = 0; k < DEPTH && ai + k < addr_log.size(); k++) check("fill_order", addr_log[ai + k], 64'h3000 + 64'(k * 64));

        // Address beat held across an ack stall.
        main_bus_reqack = 1'b0;
        nd = done_cyc_log.size();
        enq(64'h4000, rand_line(), acc);
        n = 0;
        while (!main_bus_reqcyc && n < 20) begin
            tick();
            n++;
        end
        bi = beat_log.size();
        repeat (5) tick();
        check("stall_no_data", 64'(beat_log.size()), 64'(bi));
        check("stall_addr_held", main_bus_req, 64'h4000);
        main_bus_reqack = 1'b1;
        wait_done(nd + 1, 50);
        if (len_log.size() > 0) check("stall_addr_cycles", 64'(len_log[len_log.size() - 1]), 64'd6);

        // Hazard lookup.
        abtr_grant = 1'b0;
        nd = done_cyc_log.size();
        enq(64'h1240, rand_line(), acc);
        lookup_addr = 64'h127F;
        #1;
        check("lookup_same_line", 64'(lookup_hit), 64'd1);
        lookup_addr = 64'h1280;
        #1;
        check("lookup_next_line", 64'(lookup_hit), 64'd0);
        lookup_addr = 64'h127F;
        abtr_grant  = 1'b1;
        wait_done(nd + 1, 50);
        #1;
        check("lookup_after_done", 64'(lookup_hit), 64'd0);

        // Duplicate line while ungranted.
        abtr_grant = 1'b0;
        nd = done_cyc_log.size();
        enq(64'h2000, mkline(64'h50), acc);
        enq(64'h2000, mkline(64'h60), acc);
        bi = beat_log.size();
`ifdef WBQ_COALESCE_EN
        check("dup_count", 64'(count), 64'd1);
        abtr_grant = 1'b1;
        wait_done(nd + 1, 50);
        if (beat_log.size() > bi) check("dup_merged_data", beat_log[bi], 64'h60);
`else
        check("dup_count", 64'(count), 64'd2);
        abtr_grant = 1'b1;
        wait_done(nd + 2, 80);
        if (beat_log.size() > bi + 8) begin
            check("dup_first_data", beat_log[bi], 64'h50);
            check("dup_second_data", beat_log[bi + 8], 64'h60);
        end else check("dup_beats_seen", 64'(beat_log.size() - bi), 64'd16);
`endif

        // Asynchronous reset during data beat 3.
        enq(64'h6000, mkline(64'h10), acc);
        n = 0;
        while (!(main_bus_reqcyc && main_bus_req == 64'h13) && n < 30) begin
            tick();
            n++;
        end
        check("arst_reached_beat3", 64'(main_bus_reqcyc && main_bus_req == 64'h13), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("arst_reqcyc", 64'(main_bus_reqcyc), 64'd0);
        check("arst_req", main_bus_req, 64'd0);
        check("arst_tag", 64'(main_bus_reqtag), 64'd0);
        check("arst_bus_busy", 64'(bus_busy), 64'd0);
        tick();
        check("arst_count", 64'(count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        reset = 1'b1;
        repeat (2) tick();
        check("arst_idle", 64'({abtr_reqcyc, bus_busy}), 64'd0);

        // Randomised traffic over a small line pool.
        for (int c = 0; c < 3000; c++) begin
            enq_valid       = ($urandom_range(0, 2) == 0);
            enq_addr        = 64'h5000 + 64'($urandom_range(0, 5) * 64) + 64'($urandom_range(0, 63));
            enq_data        = rand_line();
            lookup_addr     = 64'h5000 + 64'($urandom_range(0, 6) * 64) + 64'($urandom_range(0, 63));
            abtr_grant      = ($urandom_range(0, 1) == 1);
            main_bus_reqack = ($urandom_range(0, 2) != 0);
            tick();
        end
        enq_valid       = 1'b0;
        abtr_grant      = 1'b1;
        main_bus_reqack = 1'b1;
        n = 0;
        while (!(empty && !bus_busy && !abtr_reqcyc) && n < 600) begin
            tick();
            n++;
        end
        check("final_drained", 64'(empty && !bus_busy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Parametrised line-writeback engine for the system bus. Accepts dirty cache lines from the data cache into a DEPTH-entry FIFO, so that eviction does not wait for memory. Drains the FIFO one line at a time through the bus arbiter as an address beat followed by BEATS data beats. Provides a hazard lookup so that a read miss to a line still queued can be detected before it issues.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64: system bus data width.
- BUS_TAG_WIDTH, 13: system bus tag width.
- ADDR_WIDTH, 64: byte address width.
- LINE_BYTES, 64: cache line size. Must be a power of two and a multiple of BUS_DATA_WIDTH/8.
- DEPTH, 4: queue entries, a power of two ≥ 2.
- Derived: BEATS = LINE_BYTES*8/BUS_DATA_WIDTH; OFS = $clog2(LINE_BYTES).

Ports (clk/reset, then the rest):
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk, in, 1: the single clock.
  - reset, in, 1: asynchronous, active-low reset.
- Enqueue side:
  - enq_valid, in, 1: line offered.
  - enq_ready, out, 1: queue can accept.
  - enq_addr, in, ADDR_WIDTH: line address; low OFS bits ignored.
  - enq_data, in, LINE_BYTES*8: line data, beat 0 in the LSBs.
- Hazard lookup:
  - lookup_addr, in, ADDR_WIDTH: address to check.
  - lookup_hit, out, 1: combinational; some valid entry holds the same line.
- Arbiter and bus:
  - abtr_reqcyc, out, 1: request the bus from the arbiter.
  - abtr_grant, in, 1: arbiter grant.
  - bus_busy, out, 1: this block owns the bus.
  - main_bus_reqcyc, out, 1: request beat valid.
  - main_bus_reqack, in, 1: memory accepted the address beat.
  - main_bus_req, out, BUS_DATA_WIDTH: address or data beat.
  - main_bus_reqtag, out, BUS_TAG_WIDTH: request tag.
- Status:
  - count, out, $clog2(DEPTH)+1: occupied entries.
  - empty, out, 1: count==0.
  - wb_done, out, 1: one-cycle pulse when a line finishes.

## Operation
- The FIFO is circular with head/tail pointers and a count. Pointers wrap modulo DEPTH.
- enq_ready = (count != DEPTH), computed from the registered count. A pop in the same cycle does not free a slot for that cycle's enqueue.
- Enqueue fires when enq_valid && enq_ready. Enqueue and pop in the same cycle leave count unchanged.
- Drain FSM states and transitions:
  - IDLE: goes to ARB when !empty.
  - ARB: abtr_reqcyc=1. Goes to ADDR on abtr_grant; otherwise holds.
  - ADDR: main_bus_reqcyc=1; main_bus_req = {head.addr[ADDR_WIDTH-1:OFS], OFS'b0}, zero-extended; tag = WBQ_WRITE_TAG. Holds until main_bus_reqack, then goes to DATA with beat=0.
  - DATA: main_bus_reqcyc=1; main_bus_req = head.data[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]; tag = WBQ_WRITE_TAG. Sends one beat per cycle with no per-beat ack. Goes to END after beat BEATS-1.
  - END: reqcyc=0, req=0, tag=0, bus_busy=1. Pops the head and pulses wb_done, then goes to IDLE.
- bus_busy=1 in ADDR, DATA and END; 0 otherwise.
- In all states where they are not driven, main_bus_req and main_bus_reqtag are 0.
- lookup_hit compares addr[ADDR_WIDTH-1:OFS] against every valid entry, including the in-flight head.

## Timing
- Reset values:
  - All outputs 0, except enq_ready=1 and empty=1.
  - FSM is in IDLE; count, head, tail and beat are 0.
- Reset mid-transaction: the bus outputs drop asynchronously and the queue is flushed.
- Minimum latency from enqueue to the address beat: enqueue at cycle 0; count visible at cycle 1 (IDLE→ARB); with grant at cycle 2, the address beat goes out at cycle 3.
- A line occupies the bus for 1 + ack-wait + BEATS + 1 cycles.
- From END the FSM returns to IDLE. The next line is requested (ARB) no earlier than 1 cycle after IDLE.
- abtr_grant outside ARB is ignored. main_bus_reqack outside ADDR is ignored.

## Configuration
- Macro WBQ_COALESCE_EN.
  - Defined: an enqueue whose line matches a valid entry that is not locked overwrites that entry's data in place. count is unchanged, and enq_ready is forced to 1 for a matching offer even when full. The head is locked from ADDR through END.
  - Undefined: every enqueue allocates a new entry, and duplicate lines drain in order.

## Structure
- Package sysbus_pkg holds:
  - SYSBUS_WRITE, SYSBUS_MEMORY.
  - WBQ_WRITE_TAG = SYSBUS_WRITE<<12 | SYSBUS_MEMORY<<8.
  - The wbq_state_t enum {IDLE, ARB, ADDR, DATA, END}.
- One sub-module, wbq_storage: the entry arrays, pointers, count and the lookup comparators. The drain FSM lives in the top module.

## Test plan
- Single line: LINE_BYTES=64, BUS=64; addr 0x1234 with beats 0..7 = 0x10..0x17.
  - Expect the address beat 0x1200 with tag 0x1100 (SYSBUS_WRITE=1, SYSBUS_MEMORY=1).
  - Expect 8 data beats 0x10..0x17 in order, then wb_done one cycle after the last beat.
- Fill: enqueue 4 lines with the grant held low.
  - Expect count=4 and enq_ready=0; a 5th offer is not accepted.
  - Grant → drain in FIFO order; enq_ready returns 1 the cycle after the first pop.
- Ack stall: hold reqack low for 5 cycles in ADDR.
  - Expect the address beat held stable for 6 cycles and no data beat before the ack.
- Lookup: with 0x1240 queued, lookup 0x127F → hit=1; lookup 0x1280 → hit=0.
  - After wb_done for 0x1240, lookup 0x127F → hit=0.
- Async reset: assert reset at DATA beat 3.
  - Expect all bus outputs 0 in the same cycle, then count=0 and the FSM in IDLE.
- WBQ_COALESCE_EN: enqueue 0x2000 (data A) then 0x2000 (data B) while ungranted.
  - Expect count=1 and a drain of B.
  - Undefined: count=2, with A drained and then B.
